// File: rtl/iq_mux_pkg.sv
// Shared types and constants for the I/Q source selector.
// Build option: IQ_SRC_MUX_RAMP_EN adds the RAMP state to the state encoding.
package iq_mux_pkg;

   localparam int DEF_DW        = 16;
   localparam int DEF_BLANK_LEN = 4;
   localparam int RAMP_STEPS    = 3;
   localparam int CNT_W         = 8;

`ifdef IQ_SRC_MUX_RAMP_EN
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      BLANK = 2'd1,
      RAMP  = 2'd2
   } state_t;
`else
   typedef enum logic [0:0] {
      RUN   = 1'b0,
      BLANK = 1'b1
   } state_t;
`endif

endpackage

// File: rtl/iq_ramp_shift.sv
// Sign-preserving arithmetic right shift of an I/Q pair by 0..3.
// Only instantiated when IQ_SRC_MUX_RAMP_EN is defined.
module iq_ramp_shift #(
   parameter int DW = 16
) (
   input  logic [DW-1:0] i_data_i,
   input  logic [DW-1:0] i_data_q,
   input  logic [1:0]    i_shamt,
   output logic [DW-1:0] o_data_i,
   output logic [DW-1:0] o_data_q
);

   assign o_data_i = $signed(i_data_i) >>> i_shamt;
   assign o_data_q = $signed(i_data_q) >>> i_shamt;

endmodule

// File: rtl/iq_src_mux.sv
// Registered N-way I/Q source selector with blanking after every switch.
// Build option: IQ_SRC_MUX_RAMP_EN inserts a 3-sample ramp-up after the blank.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | selected source forwarded unchanged
// BLANK | new source's valid forwarded with zero data; counter = zeros still owed
// RAMP  | new source forwarded >>> counter (3,2,1); counter counts valid samples
module iq_src_mux
   import iq_mux_pkg::*;
#(
   parameter int N_SRC     = 2,
   parameter int DW        = DEF_DW,
   parameter int BLANK_LEN = DEF_BLANK_LEN,
   parameter int SW        = $clog2(N_SRC)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_SRC*DW-1:0] src_i_i,
   input  logic [N_SRC*DW-1:0] src_q_i,
   input  logic [N_SRC-1:0]    src_vld_i,
   input  logic [SW-1:0]       sel_i,
   input  logic                sel_req_i,
   output logic [DW-1:0]       out_i_o,
   output logic [DW-1:0]       out_q_o,
   output logic                out_vld_o,
   output logic [SW-1:0]       active_sel_o,
   output logic                busy_o,
   output logic                sel_err_o
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [SW-1:0]    r_active;
   logic [SW-1:0]    w_active_nxt;
   logic             w_err_nxt;
   logic             w_sel_oob;

   logic [DW-1:0]    w_src_i;
   logic [DW-1:0]    w_src_q;
   logic             w_src_vld;
   logic [DW-1:0]    w_out_i_nxt;
   logic [DW-1:0]    w_out_q_nxt;

   logic [DW-1:0]    r_out_i;
   logic [DW-1:0]    r_out_q;
   logic             r_out_vld;
   logic             r_busy;
   logic             r_err;

   assign w_sel_oob = ({1'b0, sel_i} >= (SW+1)'(N_SRC));

   // N-way select of the currently routed source
   always_comb begin
      w_src_i   = '0;
      w_src_q   = '0;
      w_src_vld = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         if (r_active == SW'(k)) begin
            w_src_i   = src_i_i[k*DW +: DW];
            w_src_q   = src_q_i[k*DW +: DW];
            w_src_vld = src_vld_i[k];
         end
      end
   end

   // State, counter and routed-source registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= RUN;
         r_cnt    <= '0;
         r_active <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_active <= w_active_nxt;
      end
   end

   // Next state: count down valid samples, then let a legal new request override everything
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_active_nxt = r_active;
      w_err_nxt    = 1'b0;

      case (r_state)
         BLANK: begin
            if (w_src_vld) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
`ifdef IQ_SRC_MUX_RAMP_EN
                  w_state_nxt = RAMP;
                  w_cnt_nxt   = CNT_W'(RAMP_STEPS);
`else
                  w_state_nxt = RUN;
`endif
               end
            end
         end
`ifdef IQ_SRC_MUX_RAMP_EN
         RAMP: begin
            if (w_src_vld) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  w_state_nxt = RUN;
               end
            end
         end
`endif
         default: begin
            w_state_nxt = r_state;
         end
      endcase

      if (sel_req_i) begin
         if (w_sel_oob) begin
            w_err_nxt = 1'b1;
         end else if (sel_i != r_active) begin
            w_active_nxt = sel_i;
            w_cnt_nxt    = CNT_W'(BLANK_LEN);
            w_state_nxt  = BLANK;
         end
      end
   end

`ifdef IQ_SRC_MUX_RAMP_EN
   logic [DW-1:0] w_ramp_i;
   logic [DW-1:0] w_ramp_q;

   // During RAMP the remaining step count doubles as the shift amount (3, 2, 1)
   iq_ramp_shift #(
      .DW (DW)
   ) u_ramp_shift (
      .i_data_i (w_src_i),
      .i_data_q (w_src_q),
      .i_shamt  (r_cnt[1:0]),
      .o_data_i (w_ramp_i),
      .o_data_q (w_ramp_q)
   );
`endif

   // Output data per state: forwarded, zeroed, or attenuated
   always_comb begin
      w_out_i_nxt = w_src_i;
      w_out_q_nxt = w_src_q;
      case (r_state)
         BLANK: begin
            w_out_i_nxt = '0;
            w_out_q_nxt = '0;
         end
`ifdef IQ_SRC_MUX_RAMP_EN
         RAMP: begin
            w_out_i_nxt = w_ramp_i;
            w_out_q_nxt = w_ramp_q;
         end
`endif
         default: begin
            w_out_i_nxt = w_src_i;
            w_out_q_nxt = w_src_q;
         end
      endcase
   end

   // Output register; busy is registered with the data so it flags exactly the blanked/ramped samples
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_i   <= '0;
         r_out_q   <= '0;
         r_out_vld <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_out_i   <= w_out_i_nxt;
         r_out_q   <= w_out_q_nxt;
         r_out_vld <= w_src_vld;
         r_busy    <= (r_state != RUN);
         r_err     <= w_err_nxt;
      end
   end

   assign out_i_o      = r_out_i;
   assign out_q_o      = r_out_q;
   assign out_vld_o    = r_out_vld;
   assign active_sel_o = r_active;
   assign busy_o       = r_busy;
   assign sel_err_o    = r_err;

endmodule
